// File: rtl/usb_fs_sof_gen_if.sv
// SOF generator control/line bundle: enable in, differential tx lines and
// frame status out.
interface usb_fs_sof_gen_if;
    logic        enable;
    logic        usb_p_tx;
    logic        usb_n_tx;
    logic        usb_tx_en;
    logic [10:0] frame_index;
    logic        sof_sent;

    modport master (
        input  enable,
        output usb_p_tx, usb_n_tx, usb_tx_en, frame_index, sof_sent
    );

    modport slave (
        output enable,
        input  usb_p_tx, usb_n_tx, usb_tx_en, frame_index, sof_sent
    );
endinterface

// File: rtl/usb_fs_sof_gen.sv
// Full-speed USB SOF transmitter: one SYNC/PID/frame/CRC5/EOP packet per frame,
// 4 clocks per bit, bit-stuffed and NRZI-encoded onto the tx lines.
module usb_fs_sof_gen #(
    parameter int unsigned FRAME_CLKS = 48000
) (
    input  logic             clk_48mhz,
    input  logic             reset,
    usb_fs_sof_gen_if.master bus
);
    localparam int unsigned CNT_W   = $clog2(FRAME_CLKS);
    localparam int unsigned FRM_W   = 11;
    localparam logic [7:0]  PID_SOF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_FRAME, S_CRC, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t           state_q;
    logic [3:0]       idx_q;
    logic [1:0]       phase_q;
    logic [2:0]       ones_q;
    logic             stuff_q;   // current bit period carries a stuffed 0
    logic             line_q;    // NRZI line level, 1 = J
    logic             start_q;
    logic [CNT_W-1:0] cnt_q;
    logic [FRM_W-1:0] frame_q;
    logic             p_q, n_q, tx_en_q, sof_q;

    state_t     adv_state, em_state;
    logic [3:0] adv_idx, em_idx;
    logic [2:0] em_ones;
    logic       em_stuff, em_raw, em_line, em_p, em_n, em_tx_en;
    logic       bit_load_c, last_clk_c;
    logic [4:0] crc_c, crc_tx_c;

    // Ones-complement of the x^5+x^2+1 remainder over the frame number, LSB first in.
    function automatic logic [4:0] crc5(input logic [FRM_W-1:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else             c = {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

    assign crc_c    = crc5(frame_q);
    assign crc_tx_c = {crc_c[0], crc_c[1], crc_c[2], crc_c[3], crc_c[4]};

    // Position following the bit currently on the line.
    always_comb begin
        adv_state = state_q;
        adv_idx   = idx_q + 4'd1;
        case (state_q)
            S_IDLE:    begin adv_state = S_SYNC; adv_idx = '0; end
            S_SYNC:    if (idx_q == 4'd7)  begin adv_state = S_PID;     adv_idx = '0; end
            S_PID:     if (idx_q == 4'd7)  begin adv_state = S_FRAME;   adv_idx = '0; end
            S_FRAME:   if (idx_q == 4'd10) begin adv_state = S_CRC;     adv_idx = '0; end
            S_CRC:     if (idx_q == 4'd4)  begin adv_state = S_EOP_SE0; adv_idx = '0; end
            S_EOP_SE0: if (idx_q == 4'd1)  begin adv_state = S_EOP_J;   adv_idx = '0; end
            default:   begin adv_state = S_IDLE; adv_idx = '0; end
        endcase
    end

    // Next bit to put on the line: a pending stuff bit, or the following payload/EOP bit.
    always_comb begin
        em_state = adv_state;
        em_idx   = adv_idx;
        em_stuff = 1'b0;
        if (stuff_q) begin
            em_state = state_q;
            em_idx   = idx_q;
        end else if ((state_q inside {S_SYNC, S_PID, S_FRAME, S_CRC}) && ones_q == 3'd6) begin
            em_stuff = 1'b1;
        end

        case (em_state)
            S_SYNC:  em_raw = (em_idx == 4'd7);
            S_PID:   em_raw = PID_SOF[em_idx[2:0]];
            S_FRAME: em_raw = frame_q[em_idx];
            S_CRC:   em_raw = crc_tx_c[em_idx[2:0]];
            default: em_raw = 1'b1;
        endcase

        em_line  = line_q;
        em_ones  = '0;
        em_p     = 1'b1;
        em_n     = 1'b0;
        em_tx_en = 1'b1;
        if (em_stuff) begin
            em_line = ~line_q;
            em_p    = em_line;
            em_n    = ~em_line;
        end else begin
            case (em_state)
                S_SYNC, S_PID, S_FRAME, S_CRC: begin
                    em_line = em_raw ? line_q : ~line_q;
                    em_ones = em_raw ? ones_q + 3'd1 : 3'd0;
                    em_p    = em_line;
                    em_n    = ~em_line;
                end
                S_EOP_SE0: begin
                    em_p = 1'b0;
                    em_n = 1'b0;
                end
                S_EOP_J: em_line = 1'b1;
                default: begin
                    em_line  = 1'b1;
                    em_tx_en = 1'b0;
                end
            endcase
        end
    end

    assign bit_load_c = (state_q == S_IDLE) ? start_q : (phase_q == 2'd3);
    assign last_clk_c = (state_q == S_EOP_J) && (phase_q == 2'd2);

    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            phase_q <= '0;
            ones_q  <= '0;
            stuff_q <= 1'b0;
            line_q  <= 1'b1;
            start_q <= 1'b0;
            cnt_q   <= '0;
            frame_q <= '0;
            p_q     <= 1'b1;
            n_q     <= 1'b0;
            tx_en_q <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && !bus.enable)       cnt_q <= '0;
            else if (cnt_q == CNT_W'(FRAME_CLKS - 1))   cnt_q <= '0;
            else                                        cnt_q <= cnt_q + CNT_W'(1);

            start_q <= (state_q == S_IDLE) && bus.enable && (cnt_q == '0);
            phase_q <= (state_q == S_IDLE) ? 2'd0 : phase_q + 2'd1;
            sof_q   <= last_clk_c;
            if (last_clk_c) frame_q <= frame_q + 11'd1;

            if (bit_load_c) begin
                state_q <= em_state;
                idx_q   <= em_idx;
                stuff_q <= em_stuff;
                ones_q  <= em_ones;
                line_q  <= em_line;
                p_q     <= em_p;
                n_q     <= em_n;
                tx_en_q <= em_tx_en;
            end
        end
    end

    assign bus.usb_p_tx    = p_q;
    assign bus.usb_n_tx    = n_q;
    assign bus.usb_tx_en   = tx_en_q;
    assign bus.frame_index = frame_q;
    assign bus.sof_sent    = sof_q;
endmodule

// File: doc/usb_fs_sof_gen.md
# usb_fs_sof_gen

Full-speed USB Start-of-Frame transmitter: the host-side counterpart of the device's SOF receive path and host-presence detector. Every 1 ms frame it serialises a complete SOF packet (SYNC, PID, 11-bit frame number, CRC5, EOP) onto the differential tx lines at 12 Mb/s from the 48 MHz clock, with bit stuffing and NRZI. It drives benches, loopback fixtures and test boards that keep a bootloader device's host-presence timer alive.

## Interface
- FRAME_CLKS, 48000: clocks per frame (1 ms at 48 MHz); legal range 200..2^20.
- clk_48mhz  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high: emit periodic SOFs; low: stop after the current packet.
- usb_p_tx  out  1  D+ drive value.
- usb_n_tx  out  1  D- drive value.
- usb_tx_en  out  1  high while a packet, including EOP, is driven.
- frame_index  out  11  frame number of the next SOF to send.
- sof_sent  out  1  one-cycle pulse when a packet's EOP completes.

## Operation
- Bit period is 4 clocks. A 2-bit phase counter advances the bit on phase 3.
- Frame counter is 0..FRAME_CLKS-1. It is held at 0 while enable=0 and the FSM is IDLE. Otherwise it wraps. A packet starts when enable=1 and the count is 0, in the IDLE state.
- FSM: IDLE -> SYNC (8 bits, 00000001) -> PID (8'hA5, LSB first) -> FRAME (frame_index, 11 bits, LSB first) -> CRC (5 bits) -> EOP_SE0 (2 bit times) -> EOP_J (1 bit time) -> IDLE.
- CRC5: polynomial x^5+x^2+1, preset 5'b11111, computed over the 11 frame bits. The ones-complement of the remainder is sent MSB first.
- Bit stuffing: count consecutive raw 1s from the first SYNC bit through the last CRC bit. After six 1s, insert a 0 bit and clear the run. A stuffed bit consumes a full bit period and does not advance the payload. A stuff bit falling after the last CRC bit is still sent before EOP.
- NRZI: a raw 0 toggles the line and a raw 1 holds it. The line state starts at J before SYNC. J is p=1,n=0; K is p=0,n=1. During EOP_SE0, p=0 and n=0. During EOP_J, p=1 and n=0.
- Outside packets: usb_tx_en=0 and the lines are at J.
- On the last clock of EOP_J: sof_sent=1, frame_index increments mod 2048 (0x7FF -> 0x000), tx_en falls next cycle.
- enable falling mid-packet: the packet completes normally and no further packet starts. enable rising while not IDLE: no effect until the next count-0.

## Timing
- Reset values: usb_p_tx=1, usb_n_tx=0, usb_tx_en=0, frame_index=0, sof_sent=0, FSM=IDLE, counters=0, NRZI state=J.
- Reset asserted mid-packet: all outputs take their reset values asynchronously, with no EOP. After release, the first SOF is sent with frame 0.
- Start latency: enable is sampled high at count 0 on edge N. usb_tx_en=1 and the first SYNC bit (K) are driven from edge N+1.
- Each bit, stuffed or not, is held exactly 4 clocks. tx_en stays high for 4*(35+S) clocks, where S is the number of stuffed bits.
- Consecutive packets start exactly FRAME_CLKS clocks apart.
- All outputs are registered, with no combinational path from enable.

## Test plan
- Reset, enable=1, frame 0x000: tx_en high exactly 140 clocks. Decoded bits are SYNC 00000001, PID A5, frame 0, CRC matching the bench reference. sof_sent pulses once, and frame_index becomes 1.
- Force frame_index to 0x7FF (run 2047 frames, or use FRAME_CLKS=200): stuff bits appear after the sixth 1 (last PID bit plus 5 frame bits) and after the twelfth 1. tx_en length is at least 4*(35+2) clocks. frame_index wraps to 0x000.
- FRAME_CLKS=200, enable held high for 10 packets: tx_en rising edges are exactly 200 clocks apart. Frame numbers are 0..9. Each EOP is SE0 for 8 clocks, then J for 4 clocks.
- enable dropped on the third clock of the PID state: the packet completes with a valid EOP, then no tx_en for 3*FRAME_CLKS clocks. Re-enable: the next SOF carries the incremented frame number.
- reset asserted during FRAME bits: lines go to J, tx_en=0 and frame_index=0 in the same cycle. After release, the first packet carries frame 0.
- The bench NRZI/unstuff decoder checks every packet over 50 frames: no run of seven identical line states before EOP, and the CRC is correct for every frame number.
